startup_seq_ctrl: RTL and testbench

- Synchronous controller that sequences the simulation/FPGA global control nets: GSR, GTS, PRLD and GRESTORE.
- Generates them from clocked counters instead of fixed-delay initial blocks.
- Arbitrates on-demand GRESTORE requests from several requesters.
- Sits at top level and drives the global-net model and any logic that needs a known startup order.

---
 rtl/startup_seq_pkg.sv | 19 +
 rtl/startup_seq_ctrl_rr_arbiter.sv | 49 ++++
 rtl/startup_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_startup_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/startup_seq_pkg.sv
// Shared types and default timing constants for the startup sequencer.
package startup_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        TOC,
        READY,
        RESTORE,
        DONE
    } state_t;

    localparam int ROC_DEF   = 16;
    localparam int TOC_DEF   = 4;
    localparam int GRES_DEF  = 8;
    localparam int NREQ_DEF  = 4;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/startup_seq_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot registered grant, pointer moves past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_n;
    logic [PW-1:0]      idx;
    logic [NUM_REQ-1:0] hot;
    logic               hit;

    // Scan from the pointer upward, wrapping, and take the first request.
    always_comb begin
        hot   = '0;
        hit   = 1'b0;
        ptr_n = ptr;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (!hit && req[idx]) begin
                hit      = 1'b1;
                hot[idx] = 1'b1;
                ptr_n    = PW'((int'(idx) + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            gnt <= '0;
            ptr <= '0;
        end else if (en) begin
            gnt <= hot;
            ptr <= ptr_n;
        end else begin
            gnt <= '0;
        end
    end

endmodule

// File: rtl/startup_seq_ctrl.sv
// Clocked GSR/GTS/PRLD/GRESTORE sequencer with round-robin restore requests.
// Define STARTUP_LOCK_WATCHDOG_EN to restart the sequence on PLL lock loss.
module startup_seq_ctrl
    import startup_seq_pkg::*;
#(
    parameter int ROC_CYCLES  = ROC_DEF,
    parameter int TOC_CYCLES  = TOC_DEF,
    parameter int GRES_CYCLES = GRES_DEF,
    parameter int NUM_REQ     = NREQ_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gsr,
    output logic               prld,
    output logic               gts,
    output logic               grestore,
    output logic               ready,
    output logic               restore_done
);

    localparam logic [CNT_W-1:0] ROC_LAST  = CNT_W'(ROC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOC_LAST  =
        CNT_W'((TOC_CYCLES > 0) ? TOC_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GRES_LAST = CNT_W'(GRES_CYCLES);
    localparam state_t LOCK_NEXT = (TOC_CYCLES == 0) ? READY : TOC;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             arb_en;
    logic             wd_trip;
    logic             gsr_n;
    logic             gts_n;
    logic             ready_n;
    logic             grestore_n;
    logic             done_n;

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        arb_en  = 1'b0;
        wd_trip = 1'b0;
        unique case (state)
            HOLD: begin
                if (cnt == ROC_LAST)
                    state_n = pll_locked ? LOCK_NEXT : WAIT_LOCK;
                else
                    cnt_n = cnt + CNT_W'(1);
            end
            WAIT_LOCK: begin
                if (pll_locked)
                    state_n = LOCK_NEXT;
            end
            TOC: begin
                if (cnt == TOC_LAST)
                    state_n = READY;
                else
                    cnt_n = cnt + CNT_W'(1);
            end
            READY: begin
                if (|req) begin
                    state_n = RESTORE;
                    arb_en  = 1'b1;
                end
            end
            // One extra count covers the grant cycle before grestore rises.
            RESTORE: begin
                if (cnt == GRES_LAST)
                    state_n = DONE;
                else
                    cnt_n = cnt + CNT_W'(1);
            end
            DONE: state_n = READY;
            default: state_n = HOLD;
        endcase
`ifdef STARTUP_LOCK_WATCHDOG_EN
        if (!pll_locked &&
            (state == TOC || state == READY || state == RESTORE)) begin
            state_n = HOLD;
            cnt_n   = '0;
            arb_en  = 1'b0;
            wd_trip = 1'b1;
        end
`endif
        gsr_n      = (state_n == HOLD) || (state_n == WAIT_LOCK);
        gts_n      = gsr_n || (state_n == TOC);
        ready_n    = (state_n == READY);
        grestore_n = (state_n == RESTORE) && (state == RESTORE);
        done_n     = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= HOLD;
            cnt          <= '0;
            gsr          <= 1'b1;
            gts          <= 1'b1;
            grestore     <= 1'b0;
            ready        <= 1'b0;
            restore_done <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            gsr          <= gsr_n;
            gts          <= gts_n;
            grestore     <= grestore_n;
            ready        <= ready_n;
            restore_done <= done_n;
        end
    end

    assign prld = gsr;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (wd_trip),
        .en   (arb_en),
        .req  (req),
        .gnt  (gnt)
    );

endmodule

// File: tb/tb_startup_seq_ctrl.sv
// Directed bench for startup_seq_ctrl (default params plus a TOC_CYCLES=0 copy).
module tb_startup_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gsr, prld, gts, grestore, ready, restore_done;
    logic [3:0] z_req;
    logic [3:0] z_gnt;
    logic       z_gsr, z_prld, z_gts, z_grestore, z_ready, z_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       gr;
        logic       rdy;
        logic       done;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    startup_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .req(req),
        .gnt(gnt), .gsr(gsr), .prld(prld), .gts(gts),
        .grestore(grestore), .ready(ready), .restore_done(restore_done)
    );

    startup_seq_ctrl #(.TOC_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .req(z_req),
        .gnt(z_gnt), .gsr(z_gsr), .prld(z_prld), .gts(z_gts),
        .grestore(z_grestore), .ready(z_ready), .restore_done(z_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Release reset with lock high and follow gsr/gts/ready edge by edge.
    task automatic startup_check();
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("gsr_start", gsr, (e < 16));
            chk("prld_start", prld, (e < 16));
            chk("gts_start", gts, (e < 20));
            chk("ready_start", ready, (e >= 20));
            if (e == 15 || e == 16) begin
                chk("toc0_gsr", z_gsr, (e < 16));
                chk("toc0_gts", z_gts, (e < 16));
                chk("toc0_ready", z_ready, (e >= 16));
            end
        end
    endtask

    task automatic restore_body(input string tag);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk({tag, "_gr"}, grestore, 1'b1);
            chk({tag, "_rdy"}, ready, 1'b0);
            chk({tag, "_gnt"}, gnt, 4'b0);
            chk({tag, "_done"}, restore_done, 1'b0);
        end
        tick();
        chk({tag, "_done_pulse"}, restore_done, 1'b1);
        chk({tag, "_gr_off"}, grestore, 1'b0);
        tick();
        chk({tag, "_done_end"}, restore_done, 1'b0);
        chk({tag, "_rdy_back"}, ready, 1'b1);
    endtask

    int dones;
    int waited;

    initial begin
        rst_n = 1'b0;
        pll_locked = 1'b1;
        req = 4'b0;
        z_req = 4'b0;

        tbl[0] = '{req: 4'b0100, gnt: 4'b0100, gr: 1'b0, rdy: 1'b0, done: 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{req: 4'b0, gnt: 4'b0, gr: 1'b1, rdy: 1'b0, done: 1'b0};
        tbl[9]  = '{req: 4'b0, gnt: 4'b0, gr: 1'b0, rdy: 1'b0, done: 1'b1};
        tbl[10] = '{req: 4'b0, gnt: 4'b0, gr: 1'b0, rdy: 1'b1, done: 1'b0};
        tbl[11] = '{req: 4'b0, gnt: 4'b0, gr: 1'b0, rdy: 1'b1, done: 1'b0};

        repeat (3) tick();
        chk("rst_gsr", gsr, 1'b1);
        chk("rst_prld", prld, 1'b1);
        chk("rst_gts", gts, 1'b1);
        chk("rst_gr", grestore, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_done", restore_done, 1'b0);

        startup_check();

        // All four requesting: pointer starts at 0.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", gnt, 4'b0001 << (k % 4));
            chk("rr_rdy", ready, 1'b0);
            if (k == 4) req = 4'b0;
            restore_body("rr");
        end

        // Single requester; pointer is now 1.
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req;
            tick();
            chk("tbl_gnt", gnt, tbl[i].gnt);
            chk("tbl_gr", grestore, tbl[i].gr);
            chk("tbl_rdy", ready, tbl[i].rdy);
            chk("tbl_done", restore_done, tbl[i].done);
        end

        // Reset during the third grestore cycle.
        req = 4'b0001;
        tick();
        chk("mid_gnt", gnt, 4'b0001);
        req = 4'b0;
        repeat (3) tick();
        chk("mid_gr_on", grestore, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("mid_gr", grestore, 1'b0);
        chk("mid_gsr", gsr, 1'b1);
        chk("mid_gts", gts, 1'b1);
        chk("mid_rdy", ready, 1'b0);
        chk("mid_done", restore_done, 1'b0);
        tick();
        chk("mid_done2", restore_done, 1'b0);
        startup_check();

        // PLL lock arrives late.
        rst_n = 1'b0;
        pll_locked = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 46; e++) begin
            tick();
            chk("lock_gsr_hold", gsr, 1'b1);
        end
        chk("lock_toc0_gsr", z_gsr, 1'b1);
        chk("lock_toc0_gts", z_gts, 1'b1);
        pll_locked = 1'b1;
        tick();
        chk("lock_gsr_fall", gsr, 1'b0);
        chk("lock_gts_hold", gts, 1'b1);
        chk("lock_toc0_gsr_f", z_gsr, 1'b0);
        chk("lock_toc0_gts_f", z_gts, 1'b0);
        chk("lock_toc0_rdy", z_ready, 1'b1);
        repeat (3) tick();
        chk("lock_gts_48_50", gts, 1'b1);
        tick();
        chk("lock_gts_fall", gts, 1'b0);
        chk("lock_ready", ready, 1'b1);

        // Lock loss mid-restore with another request pending.
        req = 4'b0110;
        tick();
        chk("wd_gnt1", gnt, 4'b0010);
        req = 4'b0100;
        repeat (2) tick();
        pll_locked = 1'b0;
        tick();
`ifdef STARTUP_LOCK_WATCHDOG_EN
        chk("wd_gsr", gsr, 1'b1);
        chk("wd_gr", grestore, 1'b0);
        chk("wd_rdy", ready, 1'b0);
        chk("wd_done", restore_done, 1'b0);
`else
        chk("nowd_gsr", gsr, 1'b0);
        chk("nowd_gr", grestore, 1'b1);
`endif
        pll_locked = 1'b1;
        dones = 0;
        waited = 0;
        while (gnt == 4'b0 && waited < 80) begin
            tick();
            waited++;
            if (restore_done) dones++;
        end
        chk("wd_gnt2", gnt, 4'b0100);
        req = 4'b0;
`ifdef STARTUP_LOCK_WATCHDOG_EN
        chk("wd_dones", dones, 0);
`else
        chk("nowd_dones", dones, 1);
`endif
        restore_body("wd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
